// File: rtl/sub_16_seq.sv
// Multicycle subtractor: d = a - b - bin, DIGIT_W bits per clock, LSB digit first.
// Define SUB_FLAGS_EN to add the zero and signed-overflow flag outputs.
module sub_16_seq #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int unsigned N     = WIDTH / DIGIT_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   a_q, a_n, b_q, b_n;
    logic               brw, brw_n;
    logic [WIDTH-1:0]   d_n;
    logic               bout_n, busy_n, done_n;
    logic [DIGIT_W:0]   dig_res;
    logic [WIDTH-1:0]   d_shift;
`ifdef SUB_FLAGS_EN
    logic               a_msb, a_msb_n, b_msb, b_msb_n;
    logic               zero_n, ovf_n;
`endif

    // One digit per cycle; operands shift right so the low digit is always the active one.
    always_comb begin
        dig_res = {1'b0, a_q[DIGIT_W-1:0]} - {1'b0, b_q[DIGIT_W-1:0]}
                - {{DIGIT_W{1'b0}}, brw};
        d_shift = {dig_res[DIGIT_W-1:0], d[WIDTH-1:DIGIT_W]};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        brw_n   = brw;
        d_n     = d;
        bout_n  = bout;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef SUB_FLAGS_EN
        a_msb_n = a_msb;
        b_msb_n = b_msb;
        zero_n  = zero;
        ovf_n   = ovf;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = b;
                    brw_n   = bin;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
`ifdef SUB_FLAGS_EN
                    a_msb_n = a[WIDTH-1];
                    b_msb_n = b[WIDTH-1];
`endif
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                d_n   = d_shift;
                a_n   = a_q >> DIGIT_W;
                b_n   = b_q >> DIGIT_W;
                brw_n = dig_res[DIGIT_W];
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(N - 1)) begin
                    bout_n  = dig_res[DIGIT_W];
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
`ifdef SUB_FLAGS_EN
                    zero_n  = (d_shift == '0);
                    ovf_n   = (a_msb != b_msb) && (d_shift[WIDTH-1] != a_msb);
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Datapath and output registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            brw   <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SUB_FLAGS_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            cnt   <= cnt_n;
            a_q   <= a_n;
            b_q   <= b_n;
            brw   <= brw_n;
            d     <= d_n;
            bout  <= bout_n;
            busy  <= busy_n;
            done  <= done_n;
`ifdef SUB_FLAGS_EN
            a_msb <= a_msb_n;
            b_msb <= b_msb_n;
            zero  <= zero_n;
            ovf   <= ovf_n;
`endif
        end
    end

endmodule

// File: tb/tb_sub_16_seq.sv
// Directed bench for sub_16_seq: expected results queued at start, compared at done.
module tb_sub_16_seq;

    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] d;
    logic        bout, busy, done;
`ifdef SUB_FLAGS_EN
    logic        zero, ovf;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sub_16_seq #(.WIDTH(16), .DIGIT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .d    (d),
        .bout (bout),
        .busy (busy),
        .done (done)
`ifdef SUB_FLAGS_EN
        ,
        .zero (zero),
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: 17-bit unsigned difference, borrow is the sign bit.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        exp_t        r;
        logic [16:0] full;
        full   = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        r.d    = full[15:0];
        r.bout = full[16];
        r.zero = (full[15:0] == 16'd0);
        r.ovf  = (ma[15] != mb[15]) && (full[15] != ma[15]);
        return r;
    endfunction

    // Called at a negedge; the following posedge samples start.
    task automatic drive_start(input logic [15:0] sa, input logic [15:0] sb, input logic sbin,
                               input bit push);
        start = 1'b1;
        a     = sa;
        b     = sb;
        bin   = sbin;
        if (push) exp_q.push_back(model(sa, sb, sbin));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done (bounded), checks latency, pops and compares the scoreboard.
    task automatic wait_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_qsize"}, 32'(exp_q.size() > 0), 32'd1);
        if (done && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_d"}, 32'(d), 32'(e.d));
            chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
            chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef SUB_FLAGS_EN
            chk({tag, "_zero"}, 32'(zero), 32'(e.zero));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    initial begin
        int          dones;
        logic [15:0] ra, rb, hold_d;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtraction and busy during operation.
        drive_start(16'd80, 16'd8, 1'b0, 1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_result("sub80_8");

        // Result holds through DONE and back in IDLE.
        hold_d = d;
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
        @(negedge clk);
        chk("d_hold_idle", 32'(d), 32'(hold_d));

        drive_start(16'd80, 16'd80, 1'b0, 1'b1);
        wait_result("sub_equal");
        @(negedge clk);
        drive_start(16'd208, 16'd308, 1'b0, 1'b1);
        wait_result("sub_neg");
        @(negedge clk);
        drive_start(16'd0, 16'd0, 1'b1, 1'b1);
        wait_result("sub_bin");
        @(negedge clk);
        drive_start(16'h8000, 16'd1, 1'b0, 1'b1);
        wait_result("sub_ovf");
        @(negedge clk);

        // Start while busy is ignored.
        drive_start(16'd100, 16'd1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        a     = 16'd5;
        b     = 16'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ignored_no_early_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("ignored_done", 32'(done), 32'd1);
        if (exp_q.size() > 0) chk("ignored_d", 32'(d), 32'(exp_q.pop_front().d));
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("ignored_single_done", 32'(dones), 32'd0);

        // Back-to-back: start during the done cycle.
        drive_start(16'd1000, 16'd1, 1'b0, 1'b1);
        wait_result("b2b_first");
        drive_start(16'd7, 16'd9, 1'b0, 1'b1);
        wait_result("b2b_second");
        @(negedge clk);

        // Reset mid-operation discards the result.
        drive_start(16'd500, 16'd20, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_d", 32'(d), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        drive_start(16'd500, 16'd20, 1'b0, 1'b1);
        wait_result("after_rst");
        @(negedge clk);

        // A few random operands.
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive_start(ra, rb, 1'($urandom_range(1, 0)), 1'b1);
            wait_result("random");
            @(negedge clk);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
